// File: rtl/decoder_onehot_seq_if.sv
// Select-load handshake between control logic and decoder_onehot_seq.
// Master offers a binary select; the decoder raises sel_ready only while in direct mode.
interface decoder_onehot_seq_if #(
  parameter int SEL_W = 3
);
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             sel_ready;

  modport master (
    output sel_valid,
    output sel,
    input  sel_ready
  );

  modport slave (
    input  sel_valid,
    input  sel,
    output sel_ready
  );
endinterface

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with direct load and self-stepping scan; outputs settle one cycle after the deciding edge.
// sel_ready is a decode of the state register: high only in DIRECT, so selects offered while idle or scanning are never taken.
module decoder_onehot_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  decoder_onehot_seq_if.slave    sel_if,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [(1<<SEL_W)-1:0]  dec_out,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   wrap
);
  localparam int N = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   idx, idx_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [N-1:0]       dec_nxt;
  logic               wrap_nxt;
  logic               sel_ready;
  logic               load;
  logic               step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_ready = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else if (mode) begin
      state_nxt = SCAN;
    end else begin
      state_nxt = DIRECT;
    end
    sel_ready = (state == DIRECT);
  end

  assign sel_if.sel_ready = sel_ready;

  // Stepping needs a SCAN cycle that stays in SCAN; the edge that leaves scan
  // (to IDLE or DIRECT) freezes the index where it was shown.
  always_comb begin
    load     = sel_ready && sel_if.sel_valid;
    step     = (state == SCAN) && (state_nxt == SCAN) && (cnt == dwell);
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    dec_nxt  = '0;

    if (load) begin
      idx_nxt = sel_if.sel;
    end else if (step) begin
      idx_nxt = idx + 1'b1;
    end

    unique case (state_nxt)
      DIRECT: cnt_nxt = '0;
      SCAN: begin
        if ((state != SCAN) || step) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: cnt_nxt = cnt;
    endcase

    wrap_nxt = step && (&idx);

    if (state_nxt != IDLE) begin
      dec_nxt[idx_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      cnt     <= '0;
      dec_out <= '0;
      wrap    <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      dec_out <= dec_nxt;
      wrap    <= wrap_nxt;
    end
  end

  assign cur_sel = idx;

  // Outputs are dark or carry exactly one line, and that line is cur_sel.
  assert property (@(posedge clk) disable iff (!rst_n)
    (dec_out == '0) || ($onehot(dec_out) && dec_out[cur_sel]));

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench for decoder_onehot_seq: table of cycle vectors through a scoreboard queue,
// then dwell-change, mid-scan reset and SEL_W=1/5 sweep sequences.
module tb_decoder_onehot_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode;
  logic [3:0] dwell;
  logic [7:0] dec_out;
  logic [2:0] cur_sel;
  logic       wrap;

  logic        p_en, p_mode;
  logic [0:0]  p_dwell;
  logic [1:0]  p1_dec;
  logic [0:0]  p1_cur;
  logic        p1_wrap;
  logic [31:0] p5_dec;
  logic [4:0]  p5_cur;
  logic        p5_wrap;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq_if #(.SEL_W(3)) s_if ();
  decoder_onehot_seq_if #(.SEL_W(1)) p1_if ();
  decoder_onehot_seq_if #(.SEL_W(5)) p5_if ();

  decoder_onehot_seq #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_if(s_if),
    .dwell(dwell), .dec_out(dec_out), .cur_sel(cur_sel), .wrap(wrap)
  );

  decoder_onehot_seq #(.SEL_W(1), .DWELL_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(p_en), .mode(p_mode), .sel_if(p1_if),
    .dwell(p_dwell), .dec_out(p1_dec), .cur_sel(p1_cur), .wrap(p1_wrap)
  );

  decoder_onehot_seq #(.SEL_W(5), .DWELL_W(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(p_en), .mode(p_mode), .sel_if(p5_if),
    .dwell(p_dwell), .dec_out(p5_dec), .cur_sel(p5_cur), .wrap(p5_wrap)
  );

  typedef struct {
    logic       en, mode, vld;
    logic [2:0] sel;
    logic [3:0] dwell;
    logic [7:0] dec;
    logic [2:0] cur;
    logic       wrap, rdy;
  } vec_t;

  typedef struct {
    logic [7:0] dec;
    logic [2:0] cur;
    logic       wrap, rdy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic m, input logic v, input logic [2:0] s,
                     input logic [3:0] dw, input logic [7:0] d, input logic [2:0] c,
                     input logic w, input logic r);
    vec_t t;
    t.en = e; t.mode = m; t.vld = v; t.sel = s; t.dwell = dw;
    t.dec = d; t.cur = c; t.wrap = w; t.rdy = r;
    tbl.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [2:0] c,
                           input logic w, input logic r);
    check({tag, " dec"},  dec_out, d);
    check({tag, " cur"},  cur_sel, c);
    check({tag, " wrap"}, wrap, w);
    check({tag, " rdy"},  s_if.sel_ready, r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n, last1, last5, per1, per5;

    rst_n = 1'b0; en = 1'b1; mode = 1'b1; dwell = 4'd0;
    s_if.sel_valid = 1'b0; s_if.sel = 3'd0;
    p1_if.sel_valid = 1'b0; p1_if.sel = 1'b0;
    p5_if.sel_valid = 1'b0; p5_if.sel = 5'd0;
    p_en = 1'b0; p_mode = 1'b1; p_dwell = 1'b1;

    // Reset held with en=1/mode=1, across edges, and just after release.
    #2;
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); tick();
    check_out("reset held", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check_out("released", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("first edge", 8'h01, 3'd0, 1'b0, 1'b0);

    //   en   mode vld  sel   dwell  dec     cur   wrap rdy
    add(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'h01, 3'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 3'd5, 4'd0, 8'h20, 3'd5, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 3'd2, 4'd0, 8'h20, 3'd5, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 3'd2, 4'd0, 8'h04, 3'd2, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 3'd7, 4'd0, 8'h80, 3'd7, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 3'd6, 4'd2, 8'h40, 3'd6, 1'b0, 1'b1);
    // scan, dwell=2, from index 6
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h40, 3'd6, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h40, 3'd6, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h40, 3'd6, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h80, 3'd7, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h80, 3'd7, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h80, 3'd7, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h01, 3'd0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd2, 8'h02, 3'd1, 1'b0, 1'b0);
    // dwell=0, sel_valid held high and ignored
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h04, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h08, 3'd3, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h10, 3'd4, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h20, 3'd5, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h40, 3'd6, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h80, 3'd7, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h01, 3'd0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h02, 3'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h04, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd5, 4'd0, 8'h08, 3'd3, 1'b0, 1'b0);
    // en gap of 4 cycles at index 3, resume with dwell=1
    add(1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 8'h00, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 8'h00, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 8'h00, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 8'h00, 3'd3, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd1, 8'h08, 3'd3, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd1, 8'h08, 3'd3, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 3'd0, 4'd1, 8'h10, 3'd4, 1'b0, 1'b0);
    // back to direct; select offered while still scanning is not taken
    add(1'b1, 1'b0, 1'b1, 3'd1, 4'd1, 8'h10, 3'd4, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 3'd1, 4'd1, 8'h02, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 3'd3, 4'd1, 8'h00, 3'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'd3, 4'd1, 8'h02, 3'd1, 1'b0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; mode = tbl[i].mode; dwell = tbl[i].dwell;
      s_if.sel_valid = tbl[i].vld; s_if.sel = tbl[i].sel;
      e.dec = tbl[i].dec; e.cur = tbl[i].cur; e.wrap = tbl[i].wrap; e.rdy = tbl[i].rdy;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check_out($sformatf("row%0d", i), e.dec, e.cur, e.wrap, e.rdy);
    end

    // Dwell lowered below the running count: counter wraps through 16 first.
    s_if.sel_valid = 1'b1; s_if.sel = 3'd0; mode = 1'b0;
    tick();
    check_out("load0", 8'h01, 3'd0, 1'b0, 1'b1);
    s_if.sel_valid = 1'b0; mode = 1'b1; dwell = 4'd5;
    for (int k = 0; k < 5; k++) tick();
    check_out("cnt4", 8'h01, 3'd0, 1'b0, 1'b0);
    dwell = 4'd1;
    n = 0;
    do begin
      tick();
      n++;
    end while (cur_sel == 3'd0 && n < 40);
    check("dwell shrink edges", n, 14);
    check("dwell shrink idx", cur_sel, 3'd1);

    // Asynchronous reset mid-cycle while scanning.
    #3 rst_n = 1'b0;
    #1;
    check_out("async rst", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_out("post rst idle", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1; mode = 1'b1; dwell = 4'd0;
    tick();
    check_out("post rst scan", 8'h01, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("post rst step", 8'h02, 3'd1, 1'b0, 1'b0);

    // Parameter sweep: SEL_W=1 and SEL_W=5 with dwell=1.
    en = 1'b0;
    p_en = 1'b1; p_mode = 1'b1; p_dwell = 1'b1;
    last1 = -1; last5 = -1; per1 = 0; per5 = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      check("p1 onehot", 32'($onehot(p1_dec)), 32'd1);
      check("p5 onehot", 32'($onehot(p5_dec)), 32'd1);
      if (p1_wrap) begin
        if (last1 >= 0) per1 = c - last1;
        last1 = c;
      end
      if (p5_wrap) begin
        if (last5 >= 0) per5 = c - last5;
        last5 = c;
      end
    end
    check("p1 sweep len", per1, 4);
    check("p5 sweep len", per5, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
